// File: rtl/datapath.sv
// datapath: four-register file feeding a 32-bit ALU whose result writes back on the clock edge
module regfile #(
  parameter int WIDTH = 32,
  parameter int NREGS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [$clog2(NREGS)-1:0] addr1,
  input  logic [$clog2(NREGS)-1:0] addr2,
  input  logic [$clog2(NREGS)-1:0] addr3,
  input  logic [WIDTH-1:0]         wd,
  output logic [WIDTH-1:0]         a,
  output logic [WIDTH-1:0]         b
);
  localparam logic [WIDTH-1:0] INIT [0:NREGS-1] = '{WIDTH'(0), WIDTH'(8), WIDTH'(4), WIDTH'(3)};
  logic [WIDTH-1:0] register [0:NREGS-1] = INIT;
  assign a = register[addr1];
  assign b = register[addr2];
  // async reset reloads the power-up constants; otherwise write back the ALU result
  always_ff @(posedge clk or posedge rst)
    if (rst) register <= INIT;
    else if (wr) register[addr3] <= wd;
endmodule

// alu: eight-operation ALU with zero and signed-overflow flags
module alu #(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             overflow
);
  logic [WIDTH-1:0] sum, diff;
  assign sum  = a + b;
  assign diff = a - b;
  // operation select
  always_comb begin
    y = '0;
    case (op)
      3'b000: y = sum;
      3'b001: y = diff;
      3'b010: y = a & b;
      3'b011: y = a | b;
      3'b100: y = a ^ b;
      3'b101: y = ~(a | b);
      3'b110: y = WIDTH'($signed(a) < $signed(b));
      3'b111: y = a << b[$clog2(WIDTH)-1:0];
      default: y = '0;
    endcase
  end
  assign zero = y == '0;
  // signed overflow only exists for add and subtract
  always_comb
    overflow = op == 3'b000 ? (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]) :
               op == 3'b001 ? (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]) : 1'b0;
endmodule

module datapath #(
  parameter int WIDTH = 32,
  parameter int NREGS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [2:0]               ALUControl,
  input  logic [$clog2(NREGS)-1:0] addr1,
  input  logic [$clog2(NREGS)-1:0] addr2,
  input  logic [$clog2(NREGS)-1:0] addr3,
  output logic [WIDTH-1:0]         Result,
  output logic                     Zero,
  output logic                     Overflow
);
  logic [WIDTH-1:0] a, b;
  regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) RF (
    .clk(clk), .rst(rst), .wr(wr), .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .wd(Result), .a(a), .b(b)
  );
  alu #(.WIDTH(WIDTH)) ALU32 (
    .op(ALUControl), .a(a), .b(b), .y(Result), .zero(Zero), .overflow(Overflow)
  );
endmodule

// File: tb/tb_datapath.sv
// tb_datapath: directed scoreboard bench for the register-file/ALU datapath
module tb_datapath;
  logic clk = 0, rst = 0, wr = 0;
  logic [2:0] ALUControl = 0;
  logic [1:0] addr1 = 0, addr2 = 0, addr3 = 0;
  logic [31:0] Result;
  logic Zero, Overflow;
  int checks = 0, failures = 0;
  typedef struct packed {logic [31:0] r; logic z; logic o;} exp_t;
  exp_t q[$];

  datapath dut (.clk(clk), .rst(rst), .wr(wr), .ALUControl(ALUControl), .addr1(addr1),
                .addr2(addr2), .addr3(addr3), .Result(Result), .Zero(Zero), .Overflow(Overflow));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [1:0] a1, a2, a3, input logic w,
                       input logic [31:0] er, input logic ez, eo);
    ALUControl = op; addr1 = a1; addr2 = a2; addr3 = a3; wr = w;
    q.push_back('{er, ez, eo});
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    #1;
    if (q.size() == 0) begin
      checks++; failures++;
      $error("FAIL %s observed=no_entry expected=scoreboard_entry", tag);
    end else begin
      e = q.pop_front();
      chk({tag, "_result"}, Result, e.r);
      chk({tag, "_zero"}, {31'b0, Zero}, {31'b0, e.z});
      chk({tag, "_ovf"}, {31'b0, Overflow}, {31'b0, e.o});
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(3'b001, 1, 3, 2, 1, 32'h5, 0, 0);
    check_out("sub_r1_r3");
    tick;
    chk("r2_after_write", dut.RF.register[2], 32'h5);

    rst = 1;
    #1;
    chk("rst_r0", dut.RF.register[0], 32'h0);
    chk("rst_r1", dut.RF.register[1], 32'h8);
    chk("rst_r2", dut.RF.register[2], 32'h4);
    chk("rst_r3", dut.RF.register[3], 32'h3);
    drive(3'b000, 1, 2, 2, 1, 32'hC, 0, 0);
    check_out("add_during_rst");
    tick;
    chk("rst_blocks_write", dut.RF.register[2], 32'h4);
    rst = 0;

    drive(3'b001, 1, 1, 1, 1, 32'h0, 1, 0);
    check_out("sub_self");
    tick;
    chk("r1_zeroed", dut.RF.register[1], 32'h0);

    drive(3'b110, 1, 2, 1, 1, 32'h1, 0, 0);
    check_out("slt_0_4");
    tick;
    drive(3'b111, 2, 3, 0, 1, 32'h20, 0, 0);
    check_out("sll_4_3");
    tick;
    drive(3'b001, 0, 1, 0, 1, 32'h1F, 0, 0);
    check_out("sub_32_1");
    tick;
    drive(3'b111, 1, 0, 1, 1, 32'h80000000, 0, 0);
    check_out("sll_1_31");
    tick;
    drive(3'b101, 1, 1, 0, 1, 32'h7FFFFFFF, 0, 0);
    check_out("nor_min");
    tick;
    chk("r0_maxpos", dut.RF.register[0], 32'h7FFFFFFF);
    drive(3'b000, 0, 0, 2, 0, 32'hFFFFFFFE, 0, 1);
    check_out("add_ovf");
    drive(3'b001, 0, 0, 2, 0, 32'h0, 1, 0);
    check_out("sub_self_max");
    drive(3'b001, 1, 0, 2, 0, 32'h1, 0, 1);
    check_out("sub_ovf");
    drive(3'b110, 1, 0, 2, 0, 32'h1, 0, 0);
    check_out("slt_signed");
    tick;
    chk("r2_unchanged", dut.RF.register[2], 32'h4);

    rst = 1;
    #1;
    rst = 0;
    drive(3'b000, 1, 2, 3, 0, 32'hC, 0, 0);
    check_out("add_nowr");
    tick;
    chk("r3_kept", dut.RF.register[3], 32'h3);

    drive(3'b010, 1, 3, 0, 0, 32'h0, 1, 0);
    check_out("and");
    drive(3'b011, 1, 3, 0, 0, 32'hB, 0, 0);
    check_out("or");
    drive(3'b100, 1, 3, 0, 0, 32'hB, 0, 0);
    check_out("xor");
    drive(3'b101, 1, 3, 0, 0, 32'hFFFFFFF4, 0, 0);
    check_out("nor");
    drive(3'b110, 1, 3, 0, 0, 32'h0, 1, 0);
    check_out("slt_8_3");
    drive(3'b110, 3, 1, 0, 0, 32'h1, 0, 0);
    check_out("slt_3_8");
    drive(3'b111, 1, 3, 0, 0, 32'h40, 0, 0);
    check_out("sll");
    tick;
    chk("r0_kept", dut.RF.register[0], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
